// File: rtl/pause_responder_pkg.sv
// Shared definitions for the CPU pause responder.
//   pr_state_e : FSM encodings (also visible on the debug state output)
//   pr_cw      : counter width covering both the timeout and resume-delay loads
package pause_responder_pkg;

   typedef enum logic [1:0] {
      PR_RUN    = 2'd0,
      PR_DRAIN  = 2'd1,
      PR_PAUSED = 2'd2,
      PR_RESUME = 2'd3
   } pr_state_e;

   // Width needed to hold max(a,b); never narrower than 1 bit.
   function automatic int pr_cw(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pause_responder_down_counter.sv
// Loadable down counter that saturates at zero.
//   clk_i, rst_ni : clock, async active-low reset (clears to 0)
//   load_i, val_i : load val_i this cycle (load has priority over dec)
//   dec_i         : decrement by one unless already zero
//   zero_o        : count is zero
module pause_down_counter #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pause_responder.sv
// CPU-side pause responder: turns a raw pause level into a clean CPU halt taken
// only at a safe point (optionally vblank-aligned), with timeout fallback, an
// acknowledge, and a programmable resume delay.
//   clk_sys     : system clock
//   reset_n     : async active-low reset
//   pause_req   : pause request level
//   safe_point  : CPU at instruction boundary / bus idle this cycle
//   vblank      : vertical blank, only used when SYNC_VBLANK != 0
//   cpu_ce_in   : ungated CPU clock enable
//   cpu_ce_out  : gated CPU clock enable (combinational)
//   pause_ack   : CPU halted and held (registered)
//   forced      : current halt was entered by timeout (registered)
//   state       : FSM state for debug/OSD (registered)
module pause_responder
   import pause_responder_pkg::*;
#(
   parameter int TIMEOUT      = 4096,
   parameter int RESUME_DELAY = 4,
   parameter int SYNC_VBLANK  = 0
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       pause_req,
   input  logic       safe_point,
   input  logic       vblank,
   input  logic       cpu_ce_in,
   output logic       cpu_ce_out,
   output logic       pause_ack,
   output logic       forced,
   output logic [1:0] state
);

   localparam int CW = pr_cw(TIMEOUT, RESUME_DELAY);
   localparam logic [CW-1:0] TO_LOAD = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] RD_LOAD = CW'((RESUME_DELAY > 0) ? RESUME_DELAY - 1 : 0);

   pr_state_e     state_q, state_d;
   logic          ack_q, ack_d;
   logic          forced_q, forced_d;
   logic          cnt_load, cnt_dec, cnt_zero;
   logic [CW-1:0] cnt_val;
   logic          safe;

   assign safe = safe_point & ((SYNC_VBLANK != 0) ? vblank : 1'b1);

   // One counter serves both the drain timeout and the resume delay; the
   // two uses never overlap because each is loaded on entry to its state.
   pause_down_counter #(.W(CW)) u_cnt (
      .clk_i  (clk_sys),
      .rst_ni (reset_n),
      .load_i (cnt_load),
      .val_i  (cnt_val),
      .dec_i  (cnt_dec),
      .zero_o (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      ack_d      = ack_q;
      forced_d   = forced_q;
      cnt_load   = 1'b0;
      cnt_val    = TO_LOAD;
      cnt_dec    = 1'b0;
      cpu_ce_out = cpu_ce_in;
      unique case (state_q)
         PR_RUN: begin
            ack_d = 1'b0;
            if (pause_req) begin
               state_d  = PR_DRAIN;
               cnt_load = 1'b1;
               cnt_val  = TO_LOAD;
            end
         end
         PR_DRAIN: begin
            // Suppress the enable on the safe cycle itself so the CPU is
            // frozen exactly at the boundary it just reported.
            cpu_ce_out = cpu_ce_in & ~safe;
            if (!pause_req) begin
               state_d = PR_RUN;
            end else if (safe) begin
               state_d  = PR_PAUSED;
               ack_d    = 1'b1;
               forced_d = 1'b0;
            end else if ((TIMEOUT > 0) && cnt_zero) begin
               state_d  = PR_PAUSED;
               ack_d    = 1'b1;
               forced_d = 1'b1;
            end else if (TIMEOUT > 0) begin
               cnt_dec = 1'b1;
            end
         end
         PR_PAUSED: begin
            cpu_ce_out = 1'b0;
            if (!pause_req) begin
               ack_d = 1'b0;
               if (RESUME_DELAY == 0) begin
                  state_d  = PR_RUN;
                  forced_d = 1'b0;
               end else begin
                  state_d  = PR_RESUME;
                  cnt_load = 1'b1;
                  cnt_val  = RD_LOAD;
               end
            end
         end
         PR_RESUME: begin
            cpu_ce_out = 1'b0;
            // CPU has not stepped since the halt, so a re-request can go
            // straight back to PAUSED without draining again.
            if (pause_req) begin
               state_d = PR_PAUSED;
               ack_d   = 1'b1;
            end else if (cnt_zero) begin
               state_d  = PR_RUN;
               forced_d = 1'b0;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = PR_RUN;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= PR_RUN;
         ack_q    <= 1'b0;
         forced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         forced_q <= forced_d;
      end
   end

   assign pause_ack = ack_q;
   assign forced    = forced_q;
   assign state     = state_q;

endmodule

// File: tb/tb_pause_responder.sv
// Self-checking bench for pause_responder (TIMEOUT=16, RESUME_DELAY=4,
// SYNC_VBLANK=1). A cycle model pushes expected registered outputs to a
// scoreboard queue per driven cycle; they are popped after the edge.
module tb_pause_responder;

   localparam int TO = 16;
   localparam int RD = 4;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic       pause_req, safe_point, vblank, cpu_ce_in;
   logic       cpu_ce_out, pause_ack, forced;
   logic [1:0] state;

   pause_responder #(.TIMEOUT(TO), .RESUME_DELAY(RD), .SYNC_VBLANK(1)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .pause_req  (pause_req),
      .safe_point (safe_point),
      .vblank     (vblank),
      .cpu_ce_in  (cpu_ce_in),
      .cpu_ce_out (cpu_ce_out),
      .pause_ack  (pause_ack),
      .forced     (forced),
      .state      (state)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [1:0] st;
      logic       ack;
      logic       frc;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // reference model: cycles spent in the current state counted upward
   logic [1:0] m_st;
   logic       m_f;
   int         m_el;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic m_ce();
      logic s;
      s = safe_point & vblank;
      case (m_st)
         2'd0:    return cpu_ce_in;
         2'd1:    return cpu_ce_in & ~s;
         default: return 1'b0;
      endcase
   endfunction

   task automatic m_step();
      logic s;
      s = safe_point & vblank;
      case (m_st)
         2'd0: if (pause_req) begin m_st = 2'd1; m_el = 0; end
         2'd1: begin
            if (!pause_req)          m_st = 2'd0;
            else if (s)              begin m_st = 2'd2; m_f = 1'b0; end
            else if (m_el == TO - 1) begin m_st = 2'd2; m_f = 1'b1; end
            else                     m_el++;
         end
         2'd2: if (!pause_req) begin m_st = 2'd3; m_el = 0; end
         default: begin
            if (pause_req)           m_st = 2'd2;
            else if (m_el == RD - 1) begin m_st = 2'd0; m_f = 1'b0; end
            else                     m_el++;
         end
      endcase
   endtask

   // drive one cycle, check the combinational enable, then the registered outputs
   task automatic cyc(input logic req, input logic sp, input logic vb, input logic ce);
      exp_t e;
      @(negedge clk_sys);
      pause_req = req; safe_point = sp; vblank = vb; cpu_ce_in = ce;
      #1;
      chk("ce_out", cpu_ce_out, m_ce());
      m_step();
      sb_q.push_back('{st: m_st, ack: (m_st == 2'd2), frc: m_f});
      @(posedge clk_sys);
      #1;
      e = sb_q.pop_front();
      chk("state", state, e.st);
      chk("ack", pause_ack, e.ack);
      chk("forced", forced, e.frc);
   endtask

   initial begin
      int n;
      logic ack_seen;
      reset_n = 1'b0; pause_req = 1'b0; safe_point = 1'b0; vblank = 1'b1; cpu_ce_in = 1'b1;
      m_st = 2'd0; m_f = 1'b0; m_el = 0;
      #2;
      chk("rst_state", state, 2'd0);
      chk("rst_ack", pause_ack, 1'b0);
      chk("rst_forced", forced, 1'b0);
      chk("rst_ce", cpu_ce_out, 1'b1);
      @(negedge clk_sys); reset_n = 1'b1;

      cyc(0, 0, 1, 1);
      // safe pulse 10 cycles into DRAIN
      cyc(1, 0, 1, 1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 1, 1);
         if (state == 2'd1) n++;
      end
      chk("t2_drain_cycles", n, 10);
      cyc(1, 1, 1, 1);
      chk("t2_ack", pause_ack, 1'b1);
      chk("t2_forced", forced, 1'b0);
      cyc(1, 0, 1, 1);
      cyc(1, 1, 1, 1);

      // release with a re-request on the second delay cycle
      cyc(0, 0, 1, 1);
      chk("t5_ack_drop", pause_ack, 1'b0);
      cyc(0, 0, 1, 1);
      cyc(1, 0, 1, 1);
      chk("t5_rereq_state", state, 2'd2);
      chk("t5_rereq_ack", pause_ack, 1'b1);
      // full release: RESUME then exactly RD edges to RUN
      cyc(0, 0, 1, 1);
      n = 0;
      for (int i = 0; i < 10 && state != 2'd0; i++) begin
         cyc(0, 0, 1, 1);
         n++;
      end
      chk("t5_resume_edges", n, RD);

      // request dropped during DRAIN
      ack_seen = 1'b0;
      cyc(1, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 1, 0);
         ack_seen |= pause_ack;
      end
      cyc(0, 0, 1, 1);
      chk("t4_state", state, 2'd0);
      chk("t4_no_ack", ack_seen | pause_ack, 1'b0);

      // timeout with no safe point; edges counted from the request-sampling edge
      cyc(1, 0, 1, 1);
      n = 1;
      for (int i = 0; i < 40 && !pause_ack; i++) begin
         cyc(1, 0, 1, 1);
         n++;
      end
      chk("t3_timeout_edges", n, TO + 1);
      chk("t3_forced", forced, 1'b1);
      for (int i = 0; i < RD + 1; i++) cyc(0, 0, 1, 1);
      chk("t3_forced_clr", forced, 1'b0);

      // safe_point without vblank is ignored
      cyc(1, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1);
      chk("t6_no_halt", state, 2'd1);
      cyc(1, 1, 1, 1);
      chk("t6_vb_halt", state, 2'd2);
      chk("t6_vb_forced", forced, 1'b0);
      for (int i = 0; i < RD + 1; i++) cyc(0, 0, 1, 1);
      // safe arriving on the timeout cycle wins
      cyc(1, 0, 1, 1);
      for (int i = 0; i < TO - 1; i++) cyc(1, 0, 1, 1);
      cyc(1, 1, 1, 1);
      chk("t6_tie_state", state, 2'd2);
      chk("t6_tie_forced", forced, 1'b0);

      // async reset while PAUSED
      cyc(1, 0, 1, 1);
      @(negedge clk_sys);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_state", state, 2'd0);
      chk("t1_ack", pause_ack, 1'b0);
      chk("t1_forced", forced, 1'b0);
      chk("t1_ce_hi", cpu_ce_out, 1'b1);
      cpu_ce_in = 1'b0;
      #1;
      chk("t1_ce_lo", cpu_ce_out, 1'b0);
      m_st = 2'd0; m_f = 1'b0; m_el = 0;
      @(negedge clk_sys); reset_n = 1'b1; pause_req = 1'b0;
      cyc(0, 0, 1, 1);
      cyc(1, 0, 1, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
